// File: rtl/seg8_pkg.sv
// Shared seven-segment definitions: pattern constants, receiver FSM states and digit count.
package seg8_pkg;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned SEG_W  = 7;
    localparam int unsigned DIG_W  = $clog2(DIGITS);
    localparam int unsigned WORD_W = DIGITS * NIB_W;

    // Segment patterns a..g in bits 0..6, shared with the display driver
    localparam logic [SEG_W-1:0] SEG_0 = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1 = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2 = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3 = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4 = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5 = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6 = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7 = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8 = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9 = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_A = 7'h77;
    localparam logic [SEG_W-1:0] SEG_B = 7'h7C;
    localparam logic [SEG_W-1:0] SEG_C = 7'h39;
    localparam logic [SEG_W-1:0] SEG_D = 7'h5E;
    localparam logic [SEG_W-1:0] SEG_E = 7'h79;
    localparam logic [SEG_W-1:0] SEG_F = 7'h71;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/seg8_scan_rx_decode.sv
// seg8_decode: combinational segment pattern (decimal point excluded) to {ok, nibble}.
module seg8_decode
    import seg8_pkg::*;
(
    input  logic [SEG_W-1:0] pattern,
    output logic             ok_c,
    output logic [NIB_W-1:0] nibble_c
);

    always_comb begin
        ok_c     = 1'b1;
        nibble_c = '0;
        case (pattern)
            SEG_0:   nibble_c = 4'h0;
            SEG_1:   nibble_c = 4'h1;
            SEG_2:   nibble_c = 4'h2;
            SEG_3:   nibble_c = 4'h3;
            SEG_4:   nibble_c = 4'h4;
            SEG_5:   nibble_c = 4'h5;
            SEG_6:   nibble_c = 4'h6;
            SEG_7:   nibble_c = 4'h7;
            SEG_8:   nibble_c = 4'h8;
            SEG_9:   nibble_c = 4'h9;
            SEG_A:   nibble_c = 4'hA;
            SEG_B:   nibble_c = 4'hB;
            SEG_C:   nibble_c = 4'hC;
            SEG_D:   nibble_c = 4'hD;
            SEG_E:   nibble_c = 4'hE;
            SEG_F:   nibble_c = 4'hF;
            default: ok_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg8_scan_rx.sv
// Reconstructs a 16-bit word by snooping a multiplexed 4-digit seven-segment display.
// Optional macro SEG8_RX_DP_EN adds the dp output carrying the per-digit decimal points.
module seg8_scan_rx
    import seg8_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIGITS-1:0] drains,
    input  logic [7:0]        leds,
    output logic [WORD_W-1:0] data,
    output logic              valid,
    output logic              seg_err,
    output logic              frame_err
`ifdef SEG8_RX_DP_EN
    ,
    output logic [DIGITS-1:0] dp
`endif
);

`ifdef SEG8_RX_DP_EN
    localparam int unsigned PAT_W = 8;
`else
    localparam int unsigned PAT_W = 7;
`endif
    localparam int unsigned PAIR_W = DIGITS + PAT_W;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

    logic [DIGITS-1:0] drains_s1, drains_s2;
    logic [PAT_W-1:0]  leds_s1, leds_s2;
    logic [PAIR_W-1:0] pair_q;
    logic [CNT_W-1:0]  stab_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [DIG_W-1:0]  exp_dig;
    logic [WORD_W-1:0] word;
    state_t            state;

    logic              sample_c, dec_ok_c, timeout_c, from_idle_c;
    logic              start_c, advance_c, ooo_c, bad_c;
    logic [NIB_W-1:0]  dec_nib_c;
    logic [DIG_W-1:0]  samp_dig_c;

`ifdef SEG8_RX_DP_EN
    logic [DIGITS-1:0] dp_acc;
`else
    logic unused_dp;
    assign unused_dp = leds[7];
`endif

    // Two-flop synchronizers on the asynchronous display lines
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drains_s1 <= '0;
            drains_s2 <= '0;
            leds_s1   <= '0;
            leds_s2   <= '0;
        end else begin
            drains_s1 <= drains;
            drains_s2 <= drains_s1;
            leds_s1   <= leds[PAT_W-1:0];
            leds_s2   <= leds_s1;
        end
    end

    // stab_cnt counts how long pair_q has been held; restarts on change or non-one-hot strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pair_q   <= '0;
            stab_cnt <= '0;
        end else begin
            pair_q <= {drains_s2, leds_s2};
            if (({drains_s2, leds_s2} != pair_q) || !$onehot(drains_s2))
                stab_cnt <= '0;
            else if (stab_cnt != '1)
                stab_cnt <= stab_cnt + CNT_W'(1);
        end
    end

    assign sample_c = $onehot(pair_q[PAIR_W-1:PAT_W]) &&
                      (stab_cnt == CNT_W'(STABLE_CYCLES - 1));

    always_comb begin
        samp_dig_c = '0;
        case (pair_q[PAIR_W-1:PAT_W])
            4'b0010: samp_dig_c = 2'd1;
            4'b0100: samp_dig_c = 2'd2;
            4'b1000: samp_dig_c = 2'd3;
            default: samp_dig_c = 2'd0;
        endcase
    end

    seg8_decode u_decode (
        .pattern  (pair_q[SEG_W-1:0]),
        .ok_c     (dec_ok_c),
        .nibble_c (dec_nib_c)
    );

    // A timeout hands the coincident sample back to IDLE evaluation
    assign timeout_c   = (state == COLLECT) && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    assign from_idle_c = (state != COLLECT) || timeout_c;
    assign bad_c       = sample_c && !dec_ok_c;
    assign start_c     = sample_c && dec_ok_c && (samp_dig_c == '0);
    assign advance_c   = sample_c && dec_ok_c && !from_idle_c && (samp_dig_c == exp_dig);
    assign ooo_c       = sample_c && dec_ok_c && !from_idle_c && (samp_dig_c != exp_dig);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            exp_dig   <= '0;
            tmo_cnt   <= '0;
            word      <= '0;
            data      <= '0;
            valid     <= 1'b0;
            seg_err   <= 1'b0;
            frame_err <= 1'b0;
`ifdef SEG8_RX_DP_EN
            dp_acc    <= '0;
            dp        <= '0;
`endif
        end else begin
            valid     <= 1'b0;
            seg_err   <= 1'b0;
            frame_err <= 1'b0;
            if (state == COLLECT)
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            case (state)
                DONE: begin
                    data  <= word;
                    valid <= 1'b1;
`ifdef SEG8_RX_DP_EN
                    dp    <= dp_acc;
`endif
                    state <= IDLE;
                end
                COLLECT: begin
                    if (timeout_c) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: ;
            endcase
            if (bad_c) begin
                seg_err <= 1'b1;
                state   <= IDLE;
            end
            if (ooo_c) begin
                frame_err <= 1'b1;
                state     <= IDLE;
            end
            if (advance_c) begin
                word[{exp_dig, 2'b00} +: NIB_W] <= dec_nib_c;
`ifdef SEG8_RX_DP_EN
                dp_acc[exp_dig] <= pair_q[7];
`endif
                exp_dig <= exp_dig + DIG_W'(1);
                tmo_cnt <= '0;
                state   <= (exp_dig == DIG_W'(DIGITS - 1)) ? DONE : COLLECT;
            end
            // Digit 0 always opens a fresh frame, discarding any partial one
            if (start_c) begin
                word    <= WORD_W'(dec_nib_c);
`ifdef SEG8_RX_DP_EN
                dp_acc  <= DIGITS'(pair_q[7]);
`endif
                exp_dig <= DIG_W'(1);
                tmo_cnt <= '0;
                state   <= COLLECT;
            end
        end
    end

endmodule

// File: tb/tb_seg8_scan_rx.sv
// Directed bench for seg8_scan_rx: frame table plus multi-cycle corner sequences.
module tb_seg8_scan_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  drains;
    logic [7:0]  leds;
    logic [15:0] data;
    logic        valid, seg_err, frame_err;
`ifdef SEG8_RX_DP_EN
    logic [3:0]  dp;
`endif

    seg8_scan_rx #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(4096)) dut (
        .clk       (clk),
        .rst       (rst),
        .drains    (drains),
        .leds      (leds),
        .data      (data),
        .valid     (valid),
        .seg_err   (seg_err),
        .frame_err (frame_err)
`ifdef SEG8_RX_DP_EN
        ,
        .dp        (dp)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_valid  = 0;
    int n_seg    = 0;
    int n_frm    = 0;
    int v0, s0, f0;

    always @(negedge clk) begin
        if (valid)     n_valid++;
        if (seg_err)   n_seg++;
        if (frame_err) n_frm++;
    end

    typedef struct {
        logic [31:0] pats;      // {digit3, digit2, digit1, digit0}
        logic [15:0] exp_data;
        logic [3:0]  exp_dp;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic hold(input logic [3:0] d, input logic [7:0] l, input int n);
        drains = d;
        leds   = l;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scan(input logic [31:0] pats);
        for (int i = 0; i < 4; i++)
            hold(4'b0001 << i, pats[8*i +: 8], 8);
        hold(4'b0000, 8'h00, 6);
    endtask

    task automatic snap();
        v0 = n_valid;
        s0 = n_seg;
        f0 = n_frm;
    endtask

    task automatic check_counts(input string name, input int dv, input int ds, input int df);
        check({name, " valid"},     32'(n_valid - v0), 32'(dv));
        check({name, " seg_err"},   32'(n_seg - s0),   32'(ds));
        check({name, " frame_err"}, 32'(n_frm - f0),   32'(df));
    endtask

    initial begin
        int lat;

        vecs[0] = '{32'h6D664F5B, 16'h5432, 4'b0000};
        vecs[1] = '{32'h3F065B4F, 16'h0123, 4'b0000};
        vecs[2] = '{32'h666D7D07, 16'h4567, 4'b0000};
        vecs[3] = '{32'h7F6F777C, 16'h89AB, 4'b0000};
        vecs[4] = '{32'h395E7971, 16'hCDEF, 4'b0000};
        vecs[5] = '{32'hB95E79F1, 16'hCDEF, 4'b1001};

        rst    = 1'b1;
        drains = 4'b0000;
        leds   = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset data", 32'(data), 32'h0);
        check("reset valid", 32'(valid), 32'h0);
        check("reset seg_err", 32'(seg_err), 32'h0);
        check("reset frame_err", 32'(frame_err), 32'h0);
        rst = 1'b0;
        hold(4'b0000, 8'h00, 3);

        // Table of full frames, including an identical repeat
        foreach (vecs[i]) begin
            snap();
            scan(vecs[i].pats);
            check_counts($sformatf("frame%0d", i), 1, 0, 0);
            check($sformatf("frame%0d data", i), 32'(data), 32'(vecs[i].exp_data));
`ifdef SEG8_RX_DP_EN
            check($sformatf("frame%0d dp", i), 32'(dp), 32'(vecs[i].exp_dp));
`endif
        end

        // Out-of-order digits 0,1,3,2 then recovery
        snap();
        hold(4'b0001, 8'h5B, 8);
        hold(4'b0010, 8'h4F, 8);
        hold(4'b1000, 8'h6D, 8);
        hold(4'b0100, 8'h66, 8);
        hold(4'b0000, 8'h00, 6);
        check_counts("order", 0, 0, 1);
        check("order data held", 32'(data), 32'hCDEF);
        snap();
        scan(32'h6D664F5B);
        check_counts("order recover", 1, 0, 0);
        check("order recover data", 32'(data), 32'h5432);

        // Undecodable digit 2 pattern
        snap();
        scan(32'h06004F5B);
        check_counts("badseg", 0, 1, 0);
        check("badseg data held", 32'(data), 32'h5432);

        // Digit 0 held only 3 clocks is never sampled
        snap();
        hold(4'b0001, 8'h3F, 3);
        hold(4'b0000, 8'h00, 6);
        hold(4'b0010, 8'h06, 8);
        hold(4'b0100, 8'h5B, 8);
        hold(4'b1000, 8'h4F, 8);
        hold(4'b0000, 8'h00, 6);
        check_counts("short0", 0, 0, 0);

        // Digit 0 held exactly 4 clocks is sampled
        snap();
        hold(4'b0001, 8'h07, 4);
        hold(4'b0010, 8'h6D, 8);
        hold(4'b0100, 8'h4F, 8);
        hold(4'b1000, 8'h06, 8);
        hold(4'b0000, 8'h00, 6);
        check_counts("exact4", 1, 0, 0);
        check("exact4 data", 32'(data), 32'h1357);

        // Digit 2 held 3 clocks mid-frame makes digit 3 out of order
        snap();
        hold(4'b0001, 8'h3F, 8);
        hold(4'b0010, 8'h06, 8);
        hold(4'b0100, 8'h5B, 3);
        hold(4'b1000, 8'h4F, 8);
        hold(4'b0000, 8'h00, 6);
        check_counts("short2", 0, 0, 1);

        // Blanking and multi-hot strobes inside a frame are ignored
        snap();
        hold(4'b0001, 8'h3F, 8);
        hold(4'b0010, 8'h06, 8);
        hold(4'b0000, 8'h00, 4);
        hold(4'b0110, 8'h5B, 8);
        hold(4'b0100, 8'h5B, 8);
        hold(4'b1000, 8'h4F, 8);
        hold(4'b0000, 8'h00, 6);
        check_counts("multihot", 1, 0, 0);
        check("multihot data", 32'(data), 32'h3210);

        // Valid latency from the digit-3 pair reaching the inputs
        snap();
        hold(4'b0001, 8'h3F, 8);
        hold(4'b0010, 8'h06, 8);
        hold(4'b0100, 8'h5B, 8);
        drains = 4'b1000;
        leds   = 8'h4F;
        lat    = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (valid && lat < 0) lat = k;
        end
        @(posedge clk);
        #1;
        hold(4'b0000, 8'h00, 6);
        check("latency negedges", 32'(lat), 32'd8);
        check_counts("latency", 1, 0, 0);

        // A stall just below the timeout still completes
        snap();
        hold(4'b0001, 8'h7D, 8);
        hold(4'b0010, 8'h07, 8);
        hold(4'b0000, 8'h00, 4000);
        hold(4'b0100, 8'h7F, 8);
        hold(4'b1000, 8'h6F, 8);
        hold(4'b0000, 8'h00, 6);
        check_counts("nearstall", 1, 0, 0);
        check("nearstall data", 32'(data), 32'h9876);

        // Stall after digit 1 times out, then a full scan succeeds
        snap();
        hold(4'b0001, 8'h66, 8);
        hold(4'b0010, 8'h4F, 8);
        hold(4'b0000, 8'h00, 4200);
        hold(4'b0100, 8'h5B, 8);
        hold(4'b1000, 8'h06, 8);
        hold(4'b0000, 8'h00, 6);
        check_counts("timeout", 0, 0, 1);
        snap();
        scan(32'h065B4F66);
        check_counts("after timeout", 1, 0, 0);
        check("after timeout data", 32'(data), 32'h1234);

        // Reset mid-frame clears outputs at once; next frame needs a fresh digit 0
        hold(4'b0001, 8'h06, 8);
        hold(4'b0010, 8'h77, 8);
        hold(4'b0100, 8'h3F, 8);
        hold(4'b0000, 8'h00, 1);
        rst = 1'b1;
        #1;
        check("midreset data", 32'(data), 32'h0);
        check("midreset valid", 32'(valid), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        snap();
        hold(4'b1000, 8'h71, 8);
        hold(4'b0000, 8'h00, 6);
        check_counts("postreset lone3", 0, 0, 0);
        check("postreset data", 32'(data), 32'h0);
        snap();
        scan(32'h713FF706);
        check_counts("postreset frame", 1, 0, 0);
        check("postreset frame data", 32'(data), 32'hF0A1);
`ifdef SEG8_RX_DP_EN
        check("postreset dp", 32'(dp), 32'h2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg8_scan_rx.md
SEG8_SCAN_RX -- requirements
Module: seg8_scan_rx

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: clocks a strobe and pattern pair must hold unchanged before it is sampled; legal range 1..255.
REQ-002 Parameter TIMEOUT_CYCLES, default 4096: maximum number of clocks between samples inside a frame.
REQ-003 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1 bit: reset; asynchronous, active-high.
REQ-005 Port drains, input, 4 bits: one-hot digit strobe from the display scanner.
  - bit0 selects digit 0 (word bits 3:0).
  - bit3 selects digit 3 (word bits 15:12).
REQ-006 Port leds, input, 8 bits: segment pattern.
  - bit0..bit6 = segments a..g.
  - bit7 = decimal point.
REQ-007 Port data, output, 16 bits: last fully reconstructed word.
REQ-008 Port valid, output, 1 bit: one-cycle pulse when data updates.
REQ-009 Port seg_err, output, 1 bit: one-cycle pulse when a sampled pattern is undecodable.
REQ-010 Port frame_err, output, 1 bit: one-cycle pulse on an out-of-order digit or a timeout.

Function
REQ-011 drains and leds SHALL each pass through a 2-flop synchronizer before any use.
REQ-012 Stability counter behaviour:
  - The counter SHALL reset when synced {drains,leds} changes or drains is not one-hot.
  - Otherwise it SHALL increment, saturating.
  - Exactly one sample SHALL be taken when the count reaches STABLE_CYCLES-1.
  - No further sample SHALL be taken until the pair changes.
REQ-013 drains==0 (blanking) SHALL produce no sample and SHALL NOT break a frame.
REQ-014 Multi-hot drains SHALL be ignored and SHALL produce no sample.
REQ-015 Decode table, with bit7 masked (pattern -> nibble):
  - 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7
  - 7F->8, 6F->9, 77->A, 7C->B, 39->C, 5E->D, 79->E, 71->F
  - Any other pattern SHALL be invalid.
REQ-016 FSM states SHALL be IDLE, COLLECT and DONE.
REQ-017 IDLE transitions:
  - Digit-0 sample -> store nibble, go to COLLECT expecting digit 1.
  - Any other digit sample -> ignored.
REQ-018 COLLECT transitions:
  - Expected digit -> store nibble and advance.
  - Digit 3 stored -> go to DONE.
REQ-019 COLLECT out-of-order sample:
  - frame_err SHALL pulse and the partial frame SHALL be discarded.
  - If the sample is digit 0, it SHALL start a new frame; otherwise go to IDLE.
REQ-020 Invalid pattern in any state SHALL pulse seg_err, discard any partial frame and go to IDLE; frame_err SHALL NOT pulse.
REQ-021 COLLECT timeout: TIMEOUT_CYCLES clocks without a sample SHALL pulse frame_err and go to IDLE.
REQ-022 DONE SHALL last one cycle: data <= assembled word, valid=1, then go to IDLE.
REQ-023 Latency: valid SHALL assert 1 cycle after the digit-3 sample, i.e. 2+STABLE_CYCLES+1 clocks after the digit-3 pair becomes stable at the inputs.
REQ-024 data SHALL hold its value between valid pulses.
REQ-025 Identical consecutive frames SHALL each produce a valid pulse.
REQ-026 If a sample coincides with a timeout, the timeout SHALL take priority and the sample SHALL be evaluated from IDLE in the same cycle.

Reset
REQ-027 Asserting rst SHALL immediately set:
  - data=0, valid=0, seg_err=0, frame_err=0
  - state=IDLE, counters=0, synchronizers=0
REQ-028 rst asserted mid-frame SHALL discard the partial frame; the first frame after release SHALL begin at a fresh digit 0.

Configuration
REQ-029 Macro SEG8_RX_DP_EN defined:
  - Port dp, output, 4 bits, SHALL exist; dp[i] = bit7 of digit i.
  - dp SHALL update together with data on valid; reset value 0.
REQ-030 Macro SEG8_RX_DP_EN undefined: the dp port SHALL be absent and leds[7] SHALL be ignored.

Structure
REQ-031 Shared package seg8_pkg SHALL hold:
  - the 16 segment-pattern constants (shared with the display driver)
  - the FSM state enum
  - the digit-count constant (4)
REQ-032 One sub-module, seg8_decode, SHALL perform combinational pattern -> {ok, nibble} decoding per REQ-015.

Verification
REQ-033 Scanner drives digits 0..3 with patterns 5B,4F,66,6D, each held 8 clocks -> one valid pulse, data=16'h5432.
REQ-034 Digit order 0,1,3,2 -> frame_err pulse at the digit-3 sample, no valid; the next full scan yields valid.
REQ-035 Digit 2 pattern 0x00 -> seg_err pulse, no valid; data keeps its previous value.
REQ-036 Frame stalls after digit 1 for 4096 clocks -> frame_err pulse, state IDLE; a subsequent full scan 1234 -> data=16'h1234.
REQ-037 A pair held 3 clocks with STABLE_CYCLES=4 -> no sample; drains=4'b0110 -> no sample, no error.
REQ-038 rst pulsed after digit 2 -> outputs 0 immediately; next scan of F0A1 -> data=16'hF0A1.
  - With SEG8_RX_DP_EN: leds[7]=1 on digit 1 -> dp=4'b0010.
